// File: rtl/mdu_seq.sv
// mdu_seq: iterative MIPS multiply/divide sequencer owning the HI/LO registers
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   start, op     request (00 MUL, 01 DIV, 10 MTHI, 11 MTLO), accepted only when ready
//   sign          1 signed (MULT/DIV), 0 unsigned (MULTU/DIVU)
//   a, b          rs / rt operands
//   cancel        pipeline flush, aborts any operation in flight
//   ready, stall  idle / busy indications (combinational)
//   done          one-cycle pulse when a MUL/DIV result lands in hi/lo
//   hi, lo        HI and LO registers
module mdu_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              sign,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cancel,
    output logic              ready,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   m;
    logic [2*DATA_W-1:0] p;
    logic                neg_q, neg_r, is_div, bzero;
    logic [DATA_W-1:0]   mag_a, mag_b, q_fix, r_fix;
    logic [DATA_W:0]     msum, dt;
    logic                dge;
    logic [2*DATA_W-1:0] p_mul, p_div, prod;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = op == 2'b00 ? MUL : op == 2'b01 ? DIV : IDLE;
        if ((state == MUL || state == DIV) && cnt == LAST) state_nx = FIX;
        if (state == FIX) state_nx = IDLE;
        if (cancel) state_nx = IDLE;
        ready = state == IDLE;
        stall = state != IDLE;
    end

    // p holds {upper, lower}: product accumulator/multiplier for MUL, remainder/quotient for DIV
    always_comb begin
        mag_a = (sign && a[DATA_W-1]) ? -a : a;
        mag_b = (sign && b[DATA_W-1]) ? -b : b;
        msum  = {1'b0, p[2*DATA_W-1:DATA_W]} + {1'b0, p[0] ? m : '0};
        p_mul = {msum, p[DATA_W-1:1]};
        dt    = {p[2*DATA_W-1:DATA_W], p[DATA_W-1]};
        dge   = dt >= {1'b0, m};
        p_div = {dge ? dt[DATA_W-1:0] - m : dt[DATA_W-1:0], p[DATA_W-2:0], dge};
        prod  = neg_q ? -p : p;
        // divide-by-zero keeps the all-ones quotient regardless of operand signs
        q_fix = (neg_q && !bzero) ? -p[DATA_W-1:0] : p[DATA_W-1:0];
        r_fix = neg_r ? -p[2*DATA_W-1:DATA_W] : p[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            m      <= '0;
            p      <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            bzero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!cancel) begin
                case (state)
                    IDLE: if (start) begin
                        if (op == 2'b10) hi <= a;
                        if (op == 2'b11) lo <= a;
                        cnt    <= '0;
                        m      <= op[0] ? mag_b : mag_a;
                        p      <= {{DATA_W{1'b0}}, op[0] ? mag_a : mag_b};
                        neg_q  <= sign && (a[DATA_W-1] ^ b[DATA_W-1]);
                        neg_r  <= sign && a[DATA_W-1];
                        is_div <= op[0];
                        bzero  <= b == '0;
                    end
                    MUL: begin
                        p   <= p_mul;
                        cnt <= cnt + 1'b1;
                    end
                    DIV: begin
                        p   <= p_div;
                        cnt <= cnt + 1'b1;
                    end
                    FIX: begin
                        {hi, lo} <= is_div ? {r_fix, q_fix} : prod;
                        done     <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized and directed checks of mdu_seq against an arithmetic reference
module tb_mdu_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sign = 1'b0, cancel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        ready, stall, done;
    logic [31:0] hi, lo;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    mdu_seq #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sign(sign),
        .a(a), .b(b), .cancel(cancel), .ready(ready), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {hi, lo} from MIPS arithmetic rules
    function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int ix, iy, q, r;
        logic [63:0] ux, uy;
        if (o == 2'b00) begin
            if (s) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            ux = {32'b0, x};
            uy = {32'b0, y};
            return ux * uy;
        end
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        if (s) begin
            ix = int'(x);
            iy = int'(y);
            q = ix / iy;
            r = ix % iy;
            return {32'(r), 32'(q)};
        end
        return {x % y, x / y};
    endfunction

    // issues one MUL/DIV, pokes a spurious start while busy, checks latency and result
    task automatic run_op(input logic [1:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        int n;
        bit seen;
        e = ref_mdu(o, s, x, y);
        op = o; sign = s; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (done) seen = 1'b1;
            else begin
                if (stall) n++;
                if (c == 5) begin
                    start = 1'b1; op = {1'b0, ~o[0]}; a = ~x; b = y + 32'd1;
                end else start = 1'b0;
                tick;
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("stall_cycles", 64'(n), 64'd33);
        chk("hilo", {hi, lo}, e);
        chk("ready_at_done", 64'(ready), 64'd1);
        tick;
        chk("done_pulse", 64'(done), 64'd0);
        chk("hilo_hold", {hi, lo}, e);
    endtask

    initial begin
        logic [63:0] keep;
        logic [1:0]  o;
        logic        s;
        logic [31:0] x, y;
        tick;
        tick;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        tick;

        run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 1'b1, -32'sd3, 32'd7);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 1'b1, -32'sd7, 32'd2);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b01, 1'b0, 32'd100, 32'd0);
        chk("divu_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        run_op(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b01, 1'b1, -32'sd100, 32'd0);

        op = 2'b10; a = 32'h1234; start = 1'b1;
        tick;
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_stall", 64'(stall), 64'd0);
        op = 2'b11; a = 32'h5678;
        tick;
        start = 1'b0;
        chk("mtlo_hilo", {hi, lo}, {32'h1234, 32'h5678});
        chk("mtlo_stall", 64'(stall), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);

        keep = {hi, lo};
        op = 2'b01; sign = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cancel_ready", 64'(ready), 64'd1);
        chk("cancel_done", 64'(done), 64'd0);
        chk("cancel_hilo", {hi, lo}, keep);
        run_op(2'b01, 1'b0, 32'd1000, 32'd7);

        keep = {hi, lo};
        op = 2'b00; sign = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (32) tick;
        chk("fix_stall", 64'(stall), 64'd1);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("fixcancel_hilo", {hi, lo}, keep);
        chk("fixcancel_done", 64'(done), 64'd0);
        tick;
        chk("fixcancel_done2", 64'(done), 64'd0);

        op = 2'b00; sign = 1'b1; a = 32'd5; b = 32'd6; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(1, 0));
            s = 1'($urandom_range(1, 0));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(7, 0))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: y = 32'($urandom_range(15, 1));
                default: ;
            endcase
            run_op(o, s, x, y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
